// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit for the MIPS8 core: owns the PC, registers imem words and hands them to decode.
// Optional halt-on-sentinel detection is enabled by defining IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
   parameter int                     PC_WIDTH    = 8,
   parameter int                     INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0]    START_ADDR  = 8'h00,
   parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 16'h0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   redirect,
   input  logic [PC_WIDTH-1:0]    redirect_addr,
   output logic                   halted
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
   logic [PC_WIDTH-1:0]      instr_pc_q, instr_pc_d;
   logic                     instr_valid_q, instr_valid_d;
   logic                     halted_q, halted_d;
   logic                     load;
   logic                     halt_hit;

`ifdef IFU_HALT_DETECT_EN
   assign halt_hit = (imem_data == HALT_WORD);
`else
   // Sentinel is an ordinary instruction here, so HALT is never entered.
   assign halt_hit = 1'b0;
`endif

   assign load        = !instr_valid_q || instr_ready;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      halted_d      = halted_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
            end
         end
         RUN: begin
            // Redirect and restart both flush the word in flight; redirect wins if both fire.
            if (redirect || start) begin
               pc_d          = redirect ? redirect_addr : START_ADDR;
               instr_valid_d = 1'b0;
            end else if (load) begin
               if (halt_hit) begin
                  instr_valid_d = 1'b0;
                  state_d       = HALT;
                  halted_d      = 1'b1;
               end else begin
                  instr_d       = imem_data;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + 1'b1;
               end
            end
         end
         HALT: begin
            instr_valid_d = 1'b0;
            if (start) begin
               state_d  = RUN;
               pc_d     = START_ADDR;
               halted_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= START_ADDR;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table for streaming/stall/redirect plus
// hand sequences for halt (or PC wrap), and asynchronous reset during a stall.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [7:0]  redirect_addr = 8'h00;
   logic        halted;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .halted       (halted)
   );

   function automatic logic [15:0] rom(input logic [7:0] a);
      case (a)
         8'h00: rom = 16'h485A;
         8'h01: rom = 16'h4A14;
         8'h02: rom = 16'h4DF6;
         8'h03: rom = 16'h4F96;
         8'h04: rom = 16'h0880;
         8'h05: rom = 16'h4E02;
         8'h06: rom = 16'h6180;
         8'h07: rom = 16'h6800;
         8'h08: rom = 16'h8820;
         default: rom = 16'h0000;
      endcase
   endfunction

   always_comb imem_data = rom(imem_addr);

   typedef struct {
      logic        st;
      logic        rdy;
      logic        redir;
      logic [7:0]  raddr;
      logic        exp_valid;
      logic [15:0] exp_instr;
      logic [7:0]  exp_ipc;
      logic [7:0]  exp_addr;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic st, input logic rdy, input logic redir, input logic [7:0] raddr);
      start         = st;
      instr_ready   = rdy;
      redirect      = redir;
      redirect_addr = raddr;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [15:0] i,
                             input logic [7:0] p, input logic [7:0] a, input logic h);
      check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
      check({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, a});
      check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
      if (v) begin
         check({tag, ".instr"}, {16'd0, instr}, {16'd0, i});
         check({tag, ".instr_pc"}, {24'd0, instr_pc}, {24'd0, p});
      end
      $display("step %s: valid=%0b instr=%h pc=%h addr=%h halted=%0b",
               tag, instr_valid, instr, instr_pc, imem_addr, halted);
   endtask

   initial begin
      // start, ready, redirect, raddr, exp valid, instr, instr_pc, imem_addr
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h485A, 8'h00, 8'h01};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h4A14, 8'h01, 8'h02};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h4DF6, 8'h02, 8'h03};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h4DF6, 8'h02, 8'h03};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h4DF6, 8'h02, 8'h03};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h4DF6, 8'h02, 8'h03};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h4F96, 8'h03, 8'h04};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0880, 8'h04, 8'h05};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h485A, 8'h00, 8'h01};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h4A14, 8'h01, 8'h02};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 16'h0000, 8'h00, 8'h07};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h6800, 8'h07, 8'h08};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'h8820, 8'h08, 8'h09};

      // Reset state
      #12;
      expect_out("reset", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
      check("reset.instr", {16'd0, instr}, 32'h0);
      check("reset.instr_pc", {24'd0, instr_pc}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("idle_no_fetch", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);

      for (int k = 0; k < 15; k++) begin
         step(vecs[k].st, vecs[k].rdy, vecs[k].redir, vecs[k].raddr);
         expect_out($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_instr,
                    vecs[k].exp_ipc, vecs[k].exp_addr, 1'b0);
      end

`ifdef IFU_HALT_DETECT_EN
      // Sentinel at 09: halt, hold address, then restart
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("halt_enter", 1'b0, 16'h0, 8'h0, 8'h09, 1'b1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("halt_hold", 1'b0, 16'h0, 8'h0, 8'h09, 1'b1);
      step(1'b0, 1'b1, 1'b1, 8'h03);
      expect_out("halt_redir_ignored", 1'b0, 16'h0, 8'h0, 8'h09, 1'b1);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      expect_out("halt_restart", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("halt_refetch", 1'b1, 16'h485A, 8'h00, 8'h01, 1'b0);
`else
      // Sentinel is ordinary; then redirect near the top and wrap
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("zero_word", 1'b1, 16'h0000, 8'h09, 8'h0A, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'hFE);
      expect_out("redir_fe", 1'b0, 16'h0, 8'h0, 8'hFE, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("wrap_fe", 1'b1, 16'h0000, 8'hFE, 8'hFF, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("wrap_ff", 1'b1, 16'h0000, 8'hFF, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("wrap_00", 1'b1, 16'h485A, 8'h00, 8'h01, 1'b0);
`endif

      // Async reset during a stall with pc=05
      step(1'b1, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      expect_out("pre_reset_stall", 1'b1, 16'h0880, 8'h04, 8'h05, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      expect_out("async_reset", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
      check("async_reset.instr", {16'd0, instr}, 32'h0);
      check("async_reset.instr_pc", {24'd0, instr_pc}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("post_reset_idle", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h06);
      expect_out("idle_redir_ignored", 1'b0, 16'h0, 8'h0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      expect_out("post_reset_run", 1'b1, 16'h485A, 8'h00, 8'h01, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
